rect_pulse_seq: RTL and testbench

- Digital stimulus sequencer that generates a repeating trapezoidal pulse as a signed amplitude code.
- It sits directly upstream of a VCVS/VCCS controlled source, feeding it through a DAC model.
- Mixed-signal benches use it to drive pulse stimuli with programmable levels, slew and phase durations.
- Configuration is latched at start, so software may rewrite inputs while a run is in progress.

---
 rtl/rect_pulse_seq.sv | 183 ++++++++++++++++++
 tb/tb_rect_pulse_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_pulse_seq.sv
// rect_pulse_seq: repeating trapezoidal pulse sequencer.
// Emits a signed amplitude code that steps from u1 up to u2, holds, steps back and holds again.
// The configuration is captured on start, so the inputs may be rewritten while a run is active.
module rect_pulse_seq #(
  parameter int W  = 12,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic signed [W-1:0] u1,
  input  logic signed [W-1:0] u2,
  input  logic        [W-1:0] slew,
  input  logic       [CW-1:0] td,
  input  logic       [CW-1:0] th,
  input  logic       [CW-1:0] tl,
  input  logic       [CW-1:0] reps,
  output logic signed [W-1:0] level,
  output logic                level_vld,
  output logic                busy,
  output logic                done,
  output logic          [2:0] phase
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RISE  = 3'd2,
    HIGH  = 3'd3,
    FALL  = 3'd4,
    LOW   = 3'd5
  } state_t;

  localparam logic [W:0]    ONE_EXT = {{W{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [W-1:0]  level_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] holdCnt_q;
  logic [CW-1:0] repCnt_q;

  logic [W-1:0]  u1Lat_q;
  logic [W-1:0]  u2Lat_q;
  logic [W-1:0]  slewLat_q;
  logic [CW-1:0] tdLat_q;
  logic [CW-1:0] thLat_q;
  logic [CW-1:0] tlLat_q;
  logic [CW-1:0] repsLat_q;

  logic [W-1:0]  rampTarget;
  logic [W:0]    levelExt;
  logic [W:0]    targetExt;
  logic [W:0]    rampDiff;
  logic [W:0]    rampMag;
  logic [W:0]    slewExt;
  logic [W:0]    rampStep;
  logic          rampArrive;
  logic [W-1:0]  rampLevel_d;
  logic [CW-1:0] holdLen;
  logic          holdLast;
  logic [CW-1:0] repCnt_d;
  logic          lastPeriod;
  logic          periodEnd;

  // Ramp step toward the active target in W+1 bits, plus hold and period bookkeeping
  always_comb begin
    rampTarget  = (state_q == FALL) ? u1Lat_q : u2Lat_q;
    levelExt    = {level_q[W-1], level_q};
    targetExt   = {rampTarget[W-1], rampTarget};
    rampDiff    = targetExt - levelExt;
    rampMag     = rampDiff[W] ? (~rampDiff + ONE_EXT) : rampDiff;
    slewExt     = {1'b0, slewLat_q};
    rampArrive  = (slewLat_q == '0) || (rampMag <= slewExt);
    rampStep    = rampDiff[W] ? (levelExt - slewExt) : (levelExt + slewExt);
    rampLevel_d = rampArrive ? rampTarget : rampStep[W-1:0];

    holdLen = tlLat_q;
    if (state_q == DELAY) holdLen = tdLat_q;
    else if (state_q == HIGH) holdLen = thLat_q;
    holdLast = (holdCnt_q == holdLen - CNT_ONE);

    repCnt_d   = (repCnt_q == '1) ? repCnt_q : repCnt_q + CNT_ONE;
    lastPeriod = (repsLat_q != '0) && (repCnt_d == repsLat_q);
    periodEnd  = ((state_q == FALL) && rampArrive && (tlLat_q == '0)) ||
                 ((state_q == LOW) && holdLast);
  end

  // Sequencer FSM with registered level, busy and done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      holdCnt_q <= '0;
      repCnt_q  <= '0;
      u1Lat_q   <= '0;
      u2Lat_q   <= '0;
      slewLat_q <= '0;
      tdLat_q   <= '0;
      thLat_q   <= '0;
      tlLat_q   <= '0;
      repsLat_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop && (state_q != IDLE)) begin
        state_q   <= IDLE;
        level_q   <= u1Lat_q;
        busy_q    <= 1'b0;
        holdCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !stop) begin
              u1Lat_q   <= u1;
              u2Lat_q   <= u2;
              slewLat_q <= slew;
              tdLat_q   <= td;
              thLat_q   <= th;
              tlLat_q   <= tl;
              repsLat_q <= reps;
              level_q   <= u1;
              busy_q    <= 1'b1;
              holdCnt_q <= '0;
              repCnt_q  <= '0;
              state_q   <= (td != '0) ? DELAY : RISE;
            end
          end
          DELAY: begin
            if (holdLast) begin
              holdCnt_q <= '0;
              state_q   <= RISE;
            end else begin
              holdCnt_q <= holdCnt_q + CNT_ONE;
            end
          end
          RISE: begin
            level_q <= rampLevel_d;
            if (rampArrive) state_q <= (thLat_q != '0) ? HIGH : FALL;
          end
          HIGH: begin
            if (holdLast) begin
              holdCnt_q <= '0;
              state_q   <= FALL;
            end else begin
              holdCnt_q <= holdCnt_q + CNT_ONE;
            end
          end
          FALL: begin
            level_q <= rampLevel_d;
            if (rampArrive && (tlLat_q != '0)) state_q <= LOW;
          end
          LOW: begin
            if (holdLast) holdCnt_q <= '0;
            else holdCnt_q <= holdCnt_q + CNT_ONE;
          end
          default: state_q <= IDLE;
        endcase

        if (periodEnd) begin
          repCnt_q <= repCnt_d;
          if (lastPeriod) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RISE;
          end
        end
      end
    end
  end

  assign level     = level_q;
  assign level_vld = (state_q != IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_rect_pulse_seq.sv
// tb_rect_pulse_seq: scoreboard bench for the trapezoidal pulse sequencer.
// Stimulus pushes hand-computed output entries; a negedge monitor pops them whenever the
// sequencer presents an output (level_vld or done) and compares level, phase and flags.
module tb_rect_pulse_seq;

  typedef struct {
    int level;
    int phase;
    int done;
    int busy;
    int vld;
  } entry_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                stop;
  logic signed  [11:0] u1;
  logic signed  [11:0] u2;
  logic         [11:0] slew;
  logic         [15:0] td;
  logic         [15:0] th;
  logic         [15:0] tl;
  logic         [15:0] reps;
  logic signed  [11:0] level;
  logic                level_vld;
  logic                busy;
  logic                done;
  logic          [2:0] phase;

  int checks    = 0;
  int failures  = 0;
  int doneSeen  = 0;
  int doneStart = 0;
  entry_t expQ[$];
  entry_t monEntry;

  // Hand-computed level/phase per cycle from the start edge onward, one row per scenario
  int basicLvl[15] = '{0, 0, 0, 0, 25, 50, 75, 100, 100, 100, 75, 50, 25, 0, 0};
  int basicPh[15]  = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 4, 4, 4, 4, 5, 5};
  int ndLvl[21]    = '{-50, -50, -20, 10, 40, 50, 50, 20, -10, -40, -50,
                       -50, -20, 10, 40, 50, 50, 20, -10, -40, -50};
  int ndPh[21]     = '{1, 2, 2, 2, 2, 3, 4, 4, 4, 4, 5,
                       2, 2, 2, 2, 3, 4, 4, 4, 4, 5};
  int instLvl[6]   = '{10, -20, 10, -20, 10, -20};
  int instPh[6]    = '{2, 4, 2, 4, 2, 4};

  rect_pulse_seq #(.W(12), .CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .u1        (u1),
    .u2        (u2),
    .slew      (slew),
    .td        (td),
    .th        (th),
    .tl        (tl),
    .reps      (reps),
    .level     (level),
    .level_vld (level_vld),
    .busy      (busy),
    .done      (done),
    .phase     (phase)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck sequencer can never hang the run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: pop and compare one expected entry each time the DUT presents an output
  always @(negedge clk) begin
    if (rst_n && (level_vld || done)) begin
      if (done) doneSeen++;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output: got level=%0d phase=%0d done=%0b busy=%0b vld=%0b, required none",
                 level, phase, done, busy, level_vld);
      end else begin
        monEntry = expQ.pop_front();
        if ((int'(level) != monEntry.level) || (int'(phase) != monEntry.phase) ||
            (int'(done) != monEntry.done) || (int'(busy) != monEntry.busy) ||
            (int'(level_vld) != monEntry.vld)) begin
          failures++;
          $display("[TB] FAIL scoreboard: got level=%0d phase=%0d done=%0b busy=%0b vld=%0b, required level=%0d phase=%0d done=%0d busy=%0d vld=%0d",
                   level, phase, done, busy, level_vld,
                   monEntry.level, monEntry.phase, monEntry.done, monEntry.busy, monEntry.vld);
        end
      end
    end
  end

  // Queue one expected monitor observation
  task automatic pushExp(input int lv, input int ph, input int dn, input int bz, input int vd);
    entry_t e;
    e.level = lv;
    e.phase = ph;
    e.done  = dn;
    e.busy  = bz;
    e.vld   = vd;
    expQ.push_back(e);
  endtask

  // Direct comparison used for checks the monitor does not cover
  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Program the configuration and pulse start; returns 1 ns after the start edge
  task automatic applyStimulus(input int a1, input int a2, input int sl, input int d,
                               input int h, input int l, input int r);
    @(posedge clk);
    #1;
    u1    = 12'(a1);
    u2    = 12'(a2);
    slew  = 12'(sl);
    td    = 16'(d);
    th    = 16'(h);
    tl    = 16'(l);
    reps  = 16'(r);
    start = 1'b1;
    doneStart = doneSeen;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty, then confirm the done-pulse count
  task automatic waitDrain(input string name, input int expDone);
    int n = 0;
    while ((expQ.size() != 0) && (n < 300)) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain: got %0d entries pending, required 0", name, expQ.size());
      expQ.delete();
    end
    repeat (4) @(posedge clk);
    checkOutput({name, "_done_count"}, doneSeen - doneStart, expDone);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    u1    = '0;
    u2    = '0;
    slew  = '0;
    td    = '0;
    th    = '0;
    tl    = '0;
    reps  = '0;

    // Reset values
    #12;
    checkOutput("reset_level", int'(level), 0);
    checkOutput("reset_phase", int'(phase), 0);
    checkOutput("reset_busy",  int'(busy), 0);
    checkOutput("reset_vld",   int'(level_vld), 0);
    checkOutput("reset_done",  int'(done), 0);
    #10;
    rst_n = 1'b1;

    // Basic run: delay, ramp up, hold, ramp down, hold, then done with busy dropping
    $display("[TB] basic run");
    for (int i = 0; i < 15; i++) pushExp(basicLvl[i], basicPh[i], 0, 1, 1);
    pushExp(0, 0, 1, 0, 0);
    applyStimulus(0, 100, 25, 3, 2, 2, 1);
    waitDrain("basic", 1);

    // Non-divisible slew clamps at the target; second period skips DELAY
    $display("[TB] non-divisible slew");
    for (int i = 0; i < 21; i++) pushExp(ndLvl[i], ndPh[i], 0, 1, 1);
    pushExp(-50, 0, 1, 0, 0);
    applyStimulus(-50, 50, 30, 1, 1, 1, 2);
    waitDrain("nondiv", 1);

    // Instant step with zero holds and a downward "rise"
    $display("[TB] instant step");
    for (int i = 0; i < 6; i++) pushExp(instLvl[i], instPh[i], 0, 1, 1);
    pushExp(10, 0, 1, 0, 0);
    applyStimulus(10, -20, 0, 0, 0, 0, 3);
    waitDrain("instant", 1);

    // Stop during HIGH of an infinite run, with a simultaneous start that must be ignored
    $display("[TB] stop mid-HIGH");
    pushExp(5, 2, 0, 1, 1);
    pushExp(25, 2, 0, 1, 1);
    pushExp(45, 3, 0, 1, 1);
    pushExp(45, 3, 0, 1, 1);
    applyStimulus(5, 45, 20, 0, 5, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    stop  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    stop  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("stop_phase", int'(phase), 0);
    checkOutput("stop_level", int'(level), 5);
    checkOutput("stop_busy",  int'(busy), 0);
    checkOutput("stop_done",  int'(done), 0);
    checkOutput("stop_vld",   int'(level_vld), 0);
    waitDrain("stop", 0);
    checkOutput("stop_idle_after", int'(phase), 0);

    // Reprogramming and restarting mid-run must not disturb the waveform
    $display("[TB] start during run");
    for (int i = 0; i < 15; i++) pushExp(basicLvl[i], basicPh[i], 0, 1, 1);
    pushExp(0, 0, 1, 0, 0);
    applyStimulus(0, 100, 25, 3, 2, 2, 1);
    repeat (5) @(posedge clk);
    #1;
    u1    = -12'sd300;
    u2    = 12'sd700;
    slew  = 12'd1;
    td    = 16'd9;
    th    = 16'd9;
    tl    = 16'd9;
    reps  = 16'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain("restart", 1);

    // Asynchronous reset in the middle of RISE
    $display("[TB] reset mid-RISE");
    pushExp(0, 2, 0, 1, 1);
    pushExp(25, 2, 0, 1, 1);
    pushExp(50, 2, 0, 1, 1);
    applyStimulus(0, 100, 25, 0, 1, 1, 1);
    @(posedge clk);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_level", int'(level), 0);
    checkOutput("rst_mid_busy",  int'(busy), 0);
    checkOutput("rst_mid_phase", int'(phase), 0);
    checkOutput("rst_mid_vld",   int'(level_vld), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    waitDrain("rst_mid", 0);

    // Start still works after the reset
    $display("[TB] instant step after reset");
    for (int i = 0; i < 6; i++) pushExp(instLvl[i], instPh[i], 0, 1, 1);
    pushExp(10, 0, 1, 0, 0);
    applyStimulus(10, -20, 0, 0, 0, 0, 3);
    waitDrain("post_reset", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
